// File: rtl/srpt_data_update_arbiter_pkg.sv
// Shared definitions for the SRPT data-packet update arbiter: field layouts,
// source indices, update-type codes and record repack helpers.
package srpt_data_update_arbiter_pkg;

  localparam int unsigned SRPT_ENTRY_W = 115;
  localparam int unsigned SRPT_GRANT_W = 48;
  localparam int unsigned SRPT_DBUFF_W = 42;

  // Queue entry field ranges
  localparam int unsigned RPC_LO = 0;
  localparam int unsigned RPC_HI = 15;
  localparam int unsigned REM_LO = 16;
  localparam int unsigned REM_HI = 47;
  localparam int unsigned GR_LO  = 48;
  localparam int unsigned GR_HI  = 79;
  localparam int unsigned DB_LO  = 80;
  localparam int unsigned DB_HI  = 111;
  localparam int unsigned PRI_LO = 112;
  localparam int unsigned PRI_HI = 114;

  // Grant record field ranges
  localparam int unsigned G_RPC_HI = 15;
  localparam int unsigned G_OFF_LO = 16;
  localparam int unsigned G_OFF_HI = 47;

  // Dbuff record field ranges
  localparam int unsigned D_RPC_HI = 9;
  localparam int unsigned D_OFF_LO = 10;
  localparam int unsigned D_OFF_HI = 41;

  // Source indices into request / pick vectors
  localparam int unsigned SRC_SENDMSG = 0;
  localparam int unsigned SRC_GRANT   = 1;
  localparam int unsigned SRC_DBUFF   = 2;
  localparam int unsigned NUM_SRC     = 3;

  typedef enum logic [1:0] {
    UPD_SENDMSG = 2'd0,
    UPD_GRANT   = 2'd1,
    UPD_DBUFF   = 2'd2
  } upd_type_e;

  typedef enum logic {
    OUT_EMPTY,
    OUT_HELD
  } out_state_e;

  function automatic logic [SRPT_ENTRY_W-1:0] repack_grant(input logic [SRPT_GRANT_W-1:0] g);
    logic [SRPT_ENTRY_W-1:0] e;
    e = '0;
    e[RPC_HI:RPC_LO] = g[G_RPC_HI:0];
    e[GR_HI:GR_LO]   = g[G_OFF_HI:G_OFF_LO];
    return e;
  endfunction

  function automatic logic [SRPT_ENTRY_W-1:0] repack_dbuff(input logic [SRPT_DBUFF_W-1:0] d);
    logic [SRPT_ENTRY_W-1:0] e;
    e = '0;
    e[RPC_HI:RPC_LO] = {6'b0, d[D_RPC_HI:0]};
    e[DB_HI:DB_LO]   = d[D_OFF_HI:D_OFF_LO];
    return e;
  endfunction

endpackage

// File: rtl/srpt_data_update_arbiter_pick.sv
// Combinational 3-way pick: starved sources first (sendmsg > dbuff > grant),
// otherwise fixed priority grant > dbuff > sendmsg. Output is one-hot or zero.
module srpt_arb_pick
  import srpt_data_update_arbiter_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] starved,
  output logic [NUM_SRC-1:0] pick_oh
);

  logic [NUM_SRC-1:0] hungry;

  // Select exactly one requesting source, starvation override first
  always_comb begin
    pick_oh = '0;
    hungry  = req & starved;
    if (hungry[SRC_SENDMSG])    pick_oh[SRC_SENDMSG] = 1'b1;
    else if (hungry[SRC_DBUFF]) pick_oh[SRC_DBUFF]   = 1'b1;
    else if (hungry[SRC_GRANT]) pick_oh[SRC_GRANT]   = 1'b1;
    else if (req[SRC_GRANT])    pick_oh[SRC_GRANT]   = 1'b1;
    else if (req[SRC_DBUFF])    pick_oh[SRC_DBUFF]   = 1'b1;
    else if (req[SRC_SENDMSG])  pick_oh[SRC_SENDMSG] = 1'b1;
  end

endmodule

// File: rtl/srpt_data_update_arbiter.sv
// Merges sendmsg / grant / dbuff FWFT FIFOs into one registered update port
// for srpt_data_pkts, popping at most one FIFO per cycle.
module srpt_data_update_arbiter
  import srpt_data_update_arbiter_pkg::*;
#(
  parameter int unsigned ENTRY_W      = SRPT_ENTRY_W,
  parameter int unsigned GRANT_W      = SRPT_GRANT_W,
  parameter int unsigned DBUFF_W      = SRPT_DBUFF_W,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               cfg_pause_i,
  input  logic               sendmsg_in_empty_i,
  output logic               sendmsg_in_read_en_o,
  input  logic [ENTRY_W-1:0] sendmsg_in_data_i,
  input  logic               grant_in_empty_i,
  output logic               grant_in_read_en_o,
  input  logic [GRANT_W-1:0] grant_in_data_i,
  input  logic               dbuff_in_empty_i,
  output logic               dbuff_in_read_en_o,
  input  logic [DBUFF_W-1:0] dbuff_in_data_i,
  output logic               upd_valid_o,
  input  logic               upd_ready_i,
  output logic [1:0]         upd_type_o,
  output logic [ENTRY_W-1:0] upd_data_o,
  output logic [CNT_W-1:0]   stat_sendmsg_o,
  output logic [CNT_W-1:0]   stat_grant_o,
  output logic [CNT_W-1:0]   stat_dbuff_o
);

  localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

  out_state_e          state_q, state_d;
  logic                run_q;
  logic [NUM_SRC-1:0]  req, starved, pick_oh, pop_oh;
  logic [WAIT_W-1:0]   wait_q [NUM_SRC];
  logic                can_load, pop;
  logic [ENTRY_W-1:0]  data_q, load_data;
  upd_type_e           type_q, load_type;
  logic [CNT_W-1:0]    stat_s_q, stat_g_q, stat_d_q;

  assign req[SRC_SENDMSG] = !sendmsg_in_empty_i;
  assign req[SRC_GRANT]   = !grant_in_empty_i;
  assign req[SRC_DBUFF]   = !dbuff_in_empty_i;

  // run_q keeps pops off for the first cycle after reset is released
  assign can_load = run_q && ap_rst_n && !cfg_pause_i &&
                    ((state_q == OUT_EMPTY) || upd_ready_i);
  assign pop      = can_load && (|req);
  assign pop_oh   = pop ? pick_oh : '0;

  assign sendmsg_in_read_en_o = pop_oh[SRC_SENDMSG];
  assign grant_in_read_en_o   = pop_oh[SRC_GRANT];
  assign dbuff_in_read_en_o   = pop_oh[SRC_DBUFF];

  // A source is starved once its wait counter has saturated
  always_comb begin
    starved = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      starved[i] = (wait_q[i] == WAIT_W'(STARVE_LIMIT));
    end
  end

  srpt_arb_pick u_pick (
    .req     (req),
    .starved (starved),
    .pick_oh (pick_oh)
  );

  // Repack the chosen record into queue-entry format
  always_comb begin
    load_type = UPD_SENDMSG;
    load_data = sendmsg_in_data_i;
    if (pick_oh[SRC_GRANT]) begin
      load_type = UPD_GRANT;
      load_data = repack_grant(grant_in_data_i);
    end else if (pick_oh[SRC_DBUFF]) begin
      load_type = UPD_DBUFF;
      load_data = repack_dbuff(dbuff_in_data_i);
    end
  end

  // Output register next state: load on pop, retire on ready otherwise
  always_comb begin
    state_d = state_q;
    if (pop)                                         state_d = OUT_HELD;
    else if ((state_q == OUT_HELD) && upd_ready_i)   state_d = OUT_EMPTY;
  end

  // Output register, state and post-reset run flag
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= OUT_EMPTY;
      run_q   <= 1'b0;
      type_q  <= UPD_SENDMSG;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (pop) begin
        type_q <= load_type;
        data_q <= load_data;
      end
    end
  end

  // Wait counters: count lost pop cycles, clear when chosen or empty
  always_ff @(posedge ap_clk) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!ap_rst_n || !req[i]) begin
        wait_q[i] <= '0;
      end else if (pop) begin
        if (pop_oh[i])                             wait_q[i] <= '0;
        else if (wait_q[i] != WAIT_W'(STARVE_LIMIT)) wait_q[i] <= wait_q[i] + 1'b1;
      end
    end
  end

  // Accepted-update statistics per source, wrapping
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      stat_s_q <= '0;
      stat_g_q <= '0;
      stat_d_q <= '0;
    end else if ((state_q == OUT_HELD) && upd_ready_i) begin
      case (type_q)
        UPD_GRANT: stat_g_q <= stat_g_q + 1'b1;
        UPD_DBUFF: stat_d_q <= stat_d_q + 1'b1;
        default:   stat_s_q <= stat_s_q + 1'b1;
      endcase
    end
  end

  assign upd_valid_o    = (state_q == OUT_HELD);
  assign upd_type_o     = type_q;
  assign upd_data_o     = data_q;
  assign stat_sendmsg_o = stat_s_q;
  assign stat_grant_o   = stat_g_q;
  assign stat_dbuff_o   = stat_d_q;

endmodule

// File: tb/tb_srpt_data_update_arbiter.sv
// Scoreboard bench for srpt_data_update_arbiter: FIFO models feed the DUT,
// directed tests push hand-computed expected updates, a monitor compares them.
module tb_srpt_data_update_arbiter;

  localparam int ENTRY_W = 115;
  localparam int GRANT_W = 48;
  localparam int DBUFF_W = 42;
  localparam int CNT_W   = 32;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic               cfg_pause_i = 1'b0;
  logic               sendmsg_in_empty_i, sendmsg_in_read_en_o;
  logic [ENTRY_W-1:0] sendmsg_in_data_i;
  logic               grant_in_empty_i, grant_in_read_en_o;
  logic [GRANT_W-1:0] grant_in_data_i;
  logic               dbuff_in_empty_i, dbuff_in_read_en_o;
  logic [DBUFF_W-1:0] dbuff_in_data_i;
  logic               upd_valid_o;
  logic               upd_ready_i = 1'b1;
  logic [1:0]         upd_type_o;
  logic [ENTRY_W-1:0] upd_data_o;
  logic [CNT_W-1:0]   stat_sendmsg_o, stat_grant_o, stat_dbuff_o;

  always #5 ap_clk = ~ap_clk;

  srpt_data_update_arbiter #(
    .ENTRY_W(ENTRY_W), .GRANT_W(GRANT_W), .DBUFF_W(DBUFF_W),
    .STARVE_LIMIT(4), .CNT_W(CNT_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cfg_pause_i(cfg_pause_i),
    .sendmsg_in_empty_i(sendmsg_in_empty_i), .sendmsg_in_read_en_o(sendmsg_in_read_en_o),
    .sendmsg_in_data_i(sendmsg_in_data_i),
    .grant_in_empty_i(grant_in_empty_i), .grant_in_read_en_o(grant_in_read_en_o),
    .grant_in_data_i(grant_in_data_i),
    .dbuff_in_empty_i(dbuff_in_empty_i), .dbuff_in_read_en_o(dbuff_in_read_en_o),
    .dbuff_in_data_i(dbuff_in_data_i),
    .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i),
    .upd_type_o(upd_type_o), .upd_data_o(upd_data_o),
    .stat_sendmsg_o(stat_sendmsg_o), .stat_grant_o(stat_grant_o), .stat_dbuff_o(stat_dbuff_o)
  );

  typedef struct packed {
    logic [1:0]         t;
    logic [ENTRY_W-1:0] d;
  } exp_t;

  logic [ENTRY_W-1:0] sq[$];
  logic [GRANT_W-1:0] gq[$];
  logic [DBUFF_W-1:0] dq[$];
  exp_t               expq[$];
  int                 checks = 0;
  int                 errors = 0;
  logic [2:0]         rd;
  logic [2:0]         pop_l = '0;

  assign rd = {dbuff_in_read_en_o, grant_in_read_en_o, sendmsg_in_read_en_o};

  function automatic logic [ENTRY_W-1:0] mk(input logic [2:0] pri, input logic [31:0] db,
                                            input logic [31:0] gr, input logic [31:0] rem,
                                            input logic [15:0] rpc);
    return {pri, db, gr, rem, rpc};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic refresh();
    sendmsg_in_empty_i = (sq.size() == 0);
    sendmsg_in_data_i  = (sq.size() != 0) ? sq[0] : '0;
    grant_in_empty_i   = (gq.size() == 0);
    grant_in_data_i    = (gq.size() != 0) ? gq[0] : '0;
    dbuff_in_empty_i   = (dq.size() == 0);
    dbuff_in_data_i    = (dq.size() != 0) ? dq[0] : '0;
  endtask

  task automatic expect_upd(input logic [1:0] t, input logic [ENTRY_W-1:0] d);
    exp_t e;
    e.t = t;
    e.d = d;
    expq.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && expq.size() != 0; i++) @(posedge ap_clk);
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", expq.size());
      expq.delete();
    end
  endtask

  // FIFO model: pop on the read strobes seen just before the edge
  always @(negedge ap_clk) pop_l = rd;

  initial begin
    forever begin
      @(posedge ap_clk);
      #1;
      if (pop_l[0] && sq.size() != 0) void'(sq.pop_front());
      if (pop_l[1] && gq.size() != 0) void'(gq.pop_front());
      if (pop_l[2] && dq.size() != 0) void'(dq.pop_front());
      refresh();
    end
  end

  // Monitor: compare accepted updates and read-strobe legality
  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst_n) begin
      if (upd_valid_o && upd_ready_i) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update actual=%0h required=none", upd_data_o);
        end else begin
          e = expq.pop_front();
          chk("upd_type", 128'(upd_type_o), 128'(e.t));
          chk("upd_data", 128'(upd_data_o), 128'(e.d));
        end
      end
      if (rd != 3'b000) begin
        chk("rd_onehot", 128'($countones(rd)), 128'(1));
        chk("rd_not_paused", 128'(cfg_pause_i), 128'(0));
        chk("rd_nonempty", 128'(rd & {dbuff_in_empty_i, grant_in_empty_i, sendmsg_in_empty_i}), 128'(0));
      end
    end
  end

  initial begin
    logic [ENTRY_W-1:0] s0, s1, s4, sa, sb, sc, sp;
    logic [CNT_W+1:0]   sum_before;
    int                 r;

    s0 = mk(3'd1, 32'd11, 32'd12, 32'd13, 16'd14);
    s1 = mk(3'd0, 32'd5000, 32'd5000, 32'd10000, 16'd1);
    s4 = mk(3'd3, 32'd1, 32'd2, 32'd3, 16'h55);
    sa = mk(3'd2, 32'hA, 32'hAA, 32'hAAA, 16'hA1);
    sb = mk(3'd2, 32'hB, 32'hBB, 32'hBBB, 16'hB2);
    sc = mk(3'd2, 32'hC, 32'hCC, 32'hCCC, 16'hC3);
    sp = mk(3'd7, 32'h77, 32'h66, 32'h55, 16'h44);

    // Test 1: reset with all FIFOs non-empty
    sq.push_back(s0);
    gq.push_back({32'hDEAD, 16'h0009});
    dq.push_back({32'hBEEF, 10'h005});
    refresh();
    expect_upd(2'd1, mk(3'd0, 32'd0, 32'hDEAD, 32'd0, 16'h0009));
    expect_upd(2'd2, mk(3'd0, 32'hBEEF, 32'd0, 32'd0, 16'h0005));
    expect_upd(2'd0, s0);
    for (int i = 0; i < 2; i++) begin
      @(negedge ap_clk);
      chk("rst_rd", 128'(rd), 128'(0));
      chk("rst_valid", 128'(upd_valid_o), 128'(0));
      chk("rst_type", 128'(upd_type_o), 128'(0));
      chk("rst_data", 128'(upd_data_o), 128'(0));
      chk("rst_stats", 128'({stat_sendmsg_o, stat_grant_o, stat_dbuff_o}), 128'(0));
    end
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("rd_release_cycle", 128'(rd), 128'(0));
    @(negedge ap_clk);
    chk("first_pop_grant", 128'(rd), 128'(3'b010));
    wait_drain(20);

    // Test 2: single sendmsg, one-cycle latency
    @(posedge ap_clk);
    #2;
    sq.push_back(s1);
    refresh();
    expect_upd(2'd0, s1);
    @(negedge ap_clk);
    chk("t2_rd", 128'(rd), 128'(3'b001));
    @(negedge ap_clk);
    chk("t2_valid", 128'(upd_valid_o), 128'(1));
    chk("t2_rd_after", 128'(rd), 128'(0));
    wait_drain(10);

    // Test 3: grant beats dbuff, then dbuff next cycle
    @(posedge ap_clk);
    #2;
    gq.push_back({32'h1234, 16'd7});
    dq.push_back({32'h40, 10'd3});
    refresh();
    expect_upd(2'd1, mk(3'd0, 32'd0, 32'h1234, 32'd0, 16'd7));
    expect_upd(2'd2, mk(3'd0, 32'h40, 32'd0, 32'd0, 16'd3));
    wait_drain(10);

    // Test 4: sendmsg starves behind grants for 4 pops, then wins
    @(posedge ap_clk);
    #2;
    for (int i = 1; i <= 6; i++) gq.push_back({32'h100 + 32'(i), 16'h20 + 16'(i)});
    sq.push_back(s4);
    refresh();
    for (int i = 1; i <= 4; i++)
      expect_upd(2'd1, mk(3'd0, 32'd0, 32'h100 + 32'(i), 32'd0, 16'h20 + 16'(i)));
    expect_upd(2'd0, s4);
    for (int i = 5; i <= 6; i++)
      expect_upd(2'd1, mk(3'd0, 32'd0, 32'h100 + 32'(i), 32'd0, 16'h20 + 16'(i)));
    wait_drain(20);

    // Test 5: backpressure holds the entry, then back-to-back drain
    @(posedge ap_clk);
    #2;
    upd_ready_i = 1'b0;
    sq.push_back(sa);
    sq.push_back(sb);
    sq.push_back(sc);
    refresh();
    expect_upd(2'd0, sa);
    expect_upd(2'd0, sb);
    expect_upd(2'd0, sc);
    @(negedge ap_clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      chk("bp_valid", 128'(upd_valid_o), 128'(1));
      chk("bp_data", 128'(upd_data_o), 128'(sa));
      chk("bp_type", 128'(upd_type_o), 128'(0));
      chk("bp_rd", 128'(rd), 128'(0));
    end
    @(posedge ap_clk);
    #2 upd_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      chk("b2b_valid", 128'(upd_valid_o), 128'(1));
    end
    wait_drain(10);

    // Test 6: pause blocks pops; release yields grant, dbuff, sendmsg
    @(posedge ap_clk);
    #2;
    cfg_pause_i = 1'b1;
    sq.push_back(sp);
    gq.push_back({32'h9999, 16'h0042});
    dq.push_back({32'h7777, 10'h3FF});
    refresh();
    sum_before = (CNT_W+2)'(stat_sendmsg_o) + (CNT_W+2)'(stat_grant_o) + (CNT_W+2)'(stat_dbuff_o);
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      chk("pause_rd", 128'(rd), 128'(0));
      chk("pause_valid", 128'(upd_valid_o), 128'(0));
    end
    expect_upd(2'd1, mk(3'd0, 32'd0, 32'h9999, 32'd0, 16'h0042));
    expect_upd(2'd2, mk(3'd0, 32'h7777, 32'd0, 32'd0, 16'h03FF));
    expect_upd(2'd0, sp);
    @(posedge ap_clk);
    #2 cfg_pause_i = 1'b0;
    wait_drain(10);
    @(negedge ap_clk);
    r = int'((CNT_W+2)'(stat_sendmsg_o) + (CNT_W+2)'(stat_grant_o) + (CNT_W+2)'(stat_dbuff_o) - sum_before);
    chk("pause_stat_delta", 128'(r), 128'(3));
    chk("stat_sendmsg", 128'(stat_sendmsg_o), 128'(7));
    chk("stat_grant", 128'(stat_grant_o), 128'(9));
    chk("stat_dbuff", 128'(stat_dbuff_o), 128'(3));
    chk("idle_valid", 128'(upd_valid_o), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
